// File: rtl/line_backing_memory_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_backing_memory_if                                             |
// | Request/response bundle between the L2 snooper and backing store.  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
interface line_backing_memory_if;
  logic         en;
  logic         rden;
  logic         wren;
  logic [31:0]  addr_in;
  logic [127:0] data_in;
  logic         client_id_in;
  logic [127:0] data_out;
  logic         data_out_valid;
  logic         client_id_out;

  modport master (
    output en, rden, wren, addr_in, data_in, client_id_in,
    input  data_out, data_out_valid, client_id_out
  );

  modport slave (
    input  en, rden, wren, addr_in, data_in, client_id_in,
    output data_out, data_out_valid, client_id_out
  );
endinterface
`default_nettype wire

// File: rtl/line_backing_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | line_backing_memory                                                |
// | Non-pipelined 128-bit line store with a fixed response latency.   |
// | Optional macro MEM_WRITE_ACK_EN: pure writes return an ack.        |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module line_backing_memory #(
  parameter int LINE_ADDR_W = 9,
  parameter int LATENCY     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  line_backing_memory_if.slave bus
);

  localparam int         c_depth   = 1 << LINE_ADDR_W;
  localparam logic [7:0] c_latency = 8'(LATENCY);
  localparam logic [0:0] c_idle    = 1'b0;
  localparam logic [0:0] c_busy    = 1'b1;
`ifdef MEM_WRITE_ACK_EN
  localparam logic       c_write_ack = 1'b1;
`else
  localparam logic       c_write_ack = 1'b0;
`endif

  logic [127:0]           r_mem [c_depth] = '{default: '0};

  logic [0:0]             r_state;
  logic [0:0]             w_state_nxt;
  logic [7:0]             r_count;
  logic [LINE_ADDR_W-1:0] r_idx;
  logic [127:0]           r_wdata;
  logic                   r_client;
  logic                   r_rd;
  logic                   r_wr;
  logic [127:0]           r_data_out;
  logic                   r_valid;
  logic                   r_client_out;

  logic                   w_req;
  logic                   w_expire;
  logic                   w_accept;
  logic                   w_mem_we;
  logic                   w_resp;
  logic [127:0]           w_resp_data;
  logic                   w_unused_addr;

  // Offset bits and bits above the line index alias onto the same lines.
  assign w_unused_addr = ^{bus.addr_in[31:LINE_ADDR_W+4], bus.addr_in[3:0]};

  assign w_req    = bus.en & (bus.rden | bus.wren);
  assign w_expire = (r_state == c_busy) && (r_count == 8'd1);

  // State register plus the request/response datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= c_idle;
      r_count      <= '0;
      r_idx        <= '0;
      r_wdata      <= '0;
      r_client     <= 1'b0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_data_out   <= '0;
      r_valid      <= 1'b0;
      r_client_out <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_count  <= c_latency;
        r_idx    <= bus.addr_in[LINE_ADDR_W+3:4];
        r_wdata  <= bus.data_in;
        r_client <= bus.client_id_in;
        r_rd     <= bus.rden;
        r_wr     <= bus.wren;
      end else if (r_state == c_busy) begin
        r_count <= r_count - 8'd1;
      end
      r_valid <= w_resp;
      if (w_resp) begin
        r_data_out   <= w_resp_data;
        r_client_out <= r_client;
      end
    end
  end

  // The expiry edge can also accept the next request.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_idle:  if (w_req) w_state_nxt = c_busy;
      c_busy:  if (w_expire) w_state_nxt = w_req ? c_busy : c_idle;
      default: w_state_nxt = c_idle;
    endcase
  end

  always_comb begin
    w_accept    = w_req && ((r_state == c_idle) || w_expire);
    w_mem_we    = w_expire && r_wr;
    w_resp      = w_expire && (r_rd || (r_wr && c_write_ack));
    // A combined read+write returns the freshly written line.
    w_resp_data = r_wr ? r_wdata : r_mem[r_idx];
  end

  // State is forced IDLE by reset, so an abandoned write never lands.
  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[r_idx] <= r_wdata;
    end
  end

  assign bus.data_out       = r_data_out;
  assign bus.data_out_valid = r_valid;
  assign bus.client_id_out  = r_client_out;

endmodule
`default_nettype wire

// File: tb/tb_line_backing_memory.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_line_backing_memory                                             |
// | Directed plus random transactions against a line-array model.      |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_line_backing_memory;

  localparam int LAT   = 4;
  localparam int LINES = 512;
`ifdef MEM_WRITE_ACK_EN
  localparam bit ACK = 1'b1;
`else
  localparam bit ACK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [127:0] mdl [LINES];
  logic [127:0] exp_data = '0;
  logic         exp_cid  = 1'b0;

  line_backing_memory_if bus();

  line_backing_memory #(.LINE_ADDR_W(9), .LATENCY(LAT)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  function automatic int line_of(input logic [31:0] a);
    return int'((a >> 4) % LINES);
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic idle_out();
    bus.en = 1'b0; bus.rden = 1'b0; bus.wren = 1'b0;
  endtask

  // One request; optionally a second request is thrown in while busy.
  task automatic txn(input bit rd, input bit wr, input logic [31:0] addr,
                     input logic [127:0] data, input logic cid, input bit intrude);
    int  idx;
    bit  resp;
    idx  = line_of(addr);
    resp = rd || (wr && ACK);
    if (resp) begin
      exp_data = wr ? data : mdl[idx];
      exp_cid  = cid;
    end
    if (wr) mdl[idx] = data;

    @(negedge clk);
    bus.en = 1'b1; bus.rden = rd; bus.wren = wr;
    bus.addr_in = addr; bus.data_in = data; bus.client_id_in = cid;
    @(posedge clk);
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (intrude && k == 2) begin
        bus.en = 1'b1; bus.rden = 1'($urandom_range(0, 1)); bus.wren = 1'b1;
        bus.data_in = rnd128(); bus.client_id_in = ~cid;
      end else begin
        idle_out();
      end
      @(posedge clk);
      #1;
      check("valid", 128'(bus.data_out_valid), 128'((k == LAT) && resp));
      if (k == LAT) begin
        check("data", bus.data_out, exp_data);
        check("cid", 128'(bus.client_id_out), 128'(exp_cid));
      end
    end
  endtask

  initial begin
    logic [127:0] d_pre;
    logic [31:0]  a;
    bit           rd, wr;
    int           op;

    for (int i = 0; i < LINES; i++) mdl[i] = '0;
    idle_out();
    bus.addr_in = '0; bus.data_in = '0; bus.client_id_in = 1'b0;

    #2 reset = 1'b1;
    #1;
    check("rst_valid", 128'(bus.data_out_valid), 128'(0));
    check("rst_data", bus.data_out, 128'(0));
    check("rst_cid", 128'(bus.client_id_out), 128'(0));
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b0;

    txn(1, 0, 32'h0000, '0, 1'b1, 0);
    txn(0, 1, 32'h02B0, 128'h0974_2438_2398_3462, 1'b0, 0);
    txn(1, 0, 32'h02B4, '0, 1'b1, 0);
    txn(1, 0, 32'h22B0, '0, 1'b0, 0);

    // Write issued during a busy read must be dropped.
    txn(0, 1, 32'h0100, 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555, 1'b0, 0);
    txn(1, 0, 32'h0100, '0, 1'b1, 1);
    txn(1, 0, 32'h0100, '0, 1'b0, 0);

    // Reset two cycles into a write.
    d_pre = rnd128();
    txn(0, 1, 32'h0040, d_pre, 1'b0, 0);
    @(negedge clk);
    bus.en = 1'b1; bus.wren = 1'b1; bus.addr_in = 32'h0040;
    bus.data_in = ~d_pre; bus.client_id_in = 1'b1;
    @(posedge clk);
    @(negedge clk) idle_out();
    @(posedge clk);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    exp_data = '0; exp_cid = 1'b0;
    check("midrst_valid", 128'(bus.data_out_valid), 128'(0));
    check("midrst_data", bus.data_out, 128'(0));
    check("midrst_cid", 128'(bus.client_id_out), 128'(0));
    @(negedge clk) reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(posedge clk);
      #1;
      check("postrst_valid", 128'(bus.data_out_valid), 128'(0));
    end
    txn(1, 0, 32'h0040, '0, 1'b1, 0);

    txn(1, 1, 32'h01F0, 128'hABCD_1234, 1'b1, 0);
    txn(1, 0, 32'h01F0, '0, 1'b0, 0);
    txn(0, 1, 32'h0080, rnd128(), 1'b1, 0);
    txn(1, 0, 32'h0080, '0, 1'b0, 0);

    for (int n = 0; n < 60; n++) begin
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
        @(negedge clk);
        bus.en = 1'b0; bus.rden = 1'($urandom_range(0, 1)); bus.wren = 1'($urandom_range(0, 1));
        bus.addr_in = $urandom(); bus.data_in = rnd128();
        @(posedge clk);
        #1;
        check("en_low_valid", 128'(bus.data_out_valid), 128'(0));
      end
      op = int'($urandom_range(1, 3));
      rd = op[0];
      wr = op[1];
      a = $urandom();
      a[12:4] = 9'($urandom_range(0, 15));
      txn(rd, wr, a, rnd128(), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/line_backing_memory.md
# line_backing_memory

Cache-line-granular backing store at the bottom of the hierarchy, below the shared L2 complex. It accepts one read or write request at a time from the L2 snooper's downstream port. After a fixed latency it returns a single-cycle response carrying the 128-bit line and the requester's client ID. It is non-pipelined: requests arriving while a request is in flight are dropped.

## Interface
Parameters:
- LINE_ADDR_W, 9, line-index bits; depth = 2^LINE_ADDR_W lines of 128 bits (default 512 lines = 8 KiB, covers byte addresses 0x0000–0x1FFF).
- LATENCY, 4, cycles from request acceptance to response; legal range 1–255.

Ports:
- clk, input, 1, the single clock for the block.
- reset, input, 1, asynchronous, active-high.
- en, input, 1, request qualifier; no request is sampled while low.
- rden, input, 1, read request.
- wren, input, 1, write request.
- addr_in, input, 32, byte address.
- data_in, input, 128, write line; word k occupies bits [32k+31:32k].
- client_id_in, input, 1, requester tag.
- data_out, output, 128, response line.
- data_out_valid, output, 1, one-cycle response strobe.
- client_id_out, output, 1, tag of the request being answered.

## Operation
- Line index = addr_in[LINE_ADDR_W+3:4].
  - Bits [3:0] are ignored.
  - Bits above LINE_ADDR_W+3 are ignored, so those addresses alias onto the same lines.
- Storage is initialised to all-zero at time 0. Reset does not clear storage.
- States:
  - IDLE: accept a request on a rising edge when en=1 and (rden|wren)=1. Latch index, data_in, client_id_in and the request type, load the countdown with LATENCY, then go to BUSY.
  - BUSY: decrement the countdown each cycle. All inputs are ignored in this state; requests arriving now are dropped without any indication. When the count expires, perform the action, drive the response if one is due, and return to IDLE.
- Read: data_out = stored line, data_out_valid = 1, client_id_out = latched tag.
- Write: the store is updated at expiry. Whether a response is issued depends on MEM_WRITE_ACK_EN (see Configuration).
- rden=wren=1 together: the request is treated as a write followed by a read of the same line. The write is performed and a response is always issued, with data_out = the written data.
- en=0: rden/wren are ignored and no state changes.
- data_out and client_id_out hold their last response values until the next response. data_out_valid is high for exactly one cycle per response.

## Timing
- Request sampled at rising edge T.
- data_out_valid is high during the cycle after edge T+LATENCY.
- The earliest next acceptance is edge T+LATENCY, the same edge that raises valid. Back-to-back throughput is therefore one request per LATENCY cycles.
- Reset asserted at any time, including mid-request:
  - data_out=0, data_out_valid=0, client_id_out=0, state IDLE immediately.
  - An in-flight write is abandoned and the store is not updated.
  - An in-flight read produces no response.
- The first acceptance after reset is at the first rising edge with reset low.

## Configuration
- MEM_WRITE_ACK_EN
  - Defined: a pure write issues a response at expiry, with data_out_valid=1, data_out = the written line and client_id_out = the latched tag. The upstream snooper can then use it as a write acknowledgment.
  - Undefined: a pure write completes silently. data_out_valid stays 0, and data_out and client_id_out keep their previous values.
- rden=wren=1 responds in both builds.

## Test plan
- Reset, then read 0x0000 with client 1: valid pulses one cycle, 4 cycles after acceptance, with data_out=0 and client_id_out=1.
- Write 0x2B0 with data 0x0974_2438_2398_3462 (upper 64 bits zero), client 0, then read 0x2B4 with client 1: read data equals the written line and client_id_out=1. Reading 0x22B0 returns the same line (aliasing).
- Issue a read to 0x100, then a write to 0x100 two cycles later, during BUSY: the write is dropped, exactly one valid pulse occurs, and a later read of 0x100 returns the old line.
- Assert reset two cycles into a write to 0x040: no valid pulse, outputs read 0, and a later read of 0x040 returns the pre-write contents.
- Raise rden and wren together at 0x1F0 with data 0xABCD_1234 in word 0: one response with data_out equal to the written line, in both builds.
- Pure write to 0x080: with MEM_WRITE_ACK_EN there is one valid pulse with the written data; without it data_out_valid stays 0 throughout.
